// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared constants and types for the Ethernet MCB command-port arbiter.
//   MCB_INSTR_WR / MCB_INSTR_RD : MCB command opcodes
//   MCB_WORD_BYTES              : bytes per MCB data word (64-bit port)
//   arb_state_t                 : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package eth_pkg;

   localparam logic [2:0] MCB_INSTR_WR   = 3'b000;
   localparam logic [2:0] MCB_INSTR_RD   = 3'b001;
   localparam int         MCB_WORD_BYTES = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_t;

endpackage

// File: rtl/eth_mcb_arb.sv
// ---------------------------------------------------------------------------
// eth_mcb_arb
// Round-robin arbiter between the Ethernet RX path (DRAM writer) and the TX
// path (DRAM reader) sharing one 64-bit MCB command port. Issues at most one
// command every two cycles. Writes wait until enough words sit in the MCB
// write FIFO; reads wait until the MCB read FIFO has room for the burst.
//
// Ports
//   clk, rst                   : clock, synchronous active-high reset
//   wr_req_in/bl/addr, wr_ack  : write requester (bl = words - 1)
//   rd_req_in/bl/addr, rd_ack  : read requester
//   mcb_cmd_*_out              : MCB command interface
//   mcb_cmd_full_in            : MCB command FIFO full
//   mcb_wr_en_in, mcb_rd_en_in : monitors of MCB data FIFO push/pop strobes
//   rd_pending_out             : read words committed but not yet popped
//   err_out                    : sticky FIFO accounting error
//
// state  | meaning
// IDLE   | evaluate requests; on a grant latch the command and update credit
// ISSUE  | drive cmd strobe and the matching ack for one cycle
// ---------------------------------------------------------------------------
module eth_mcb_arb
   import eth_pkg::*;
#(
   parameter int RD_DEPTH = 64,
   parameter int WR_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        wr_req_in,
   input  logic [5:0]  wr_bl_in,
   input  logic [29:0] wr_addr_in,
   output logic        wr_ack_out,

   input  logic        rd_req_in,
   input  logic [5:0]  rd_bl_in,
   input  logic [29:0] rd_addr_in,
   output logic        rd_ack_out,

   output logic        mcb_cmd_en_out,
   output logic [2:0]  mcb_cmd_instr_out,
   output logic [5:0]  mcb_cmd_bl_out,
   output logic [29:0] mcb_cmd_byte_addr_out,
   input  logic        mcb_cmd_full_in,

   input  logic        mcb_wr_en_in,
   input  logic        mcb_rd_en_in,

   output logic [6:0]  rd_pending_out,
   output logic        err_out
);

   localparam logic [7:0]  RD_DEPTH_W = 8'(RD_DEPTH);
   localparam logic [6:0]  WR_FULL    = 7'(WR_DEPTH);
   localparam logic [29:0] ADDR_MASK  = ~30'(MCB_WORD_BYTES - 1);

   arb_state_t  r_state;
   arb_state_t  w_state_nxt;

   logic        r_last_rd;
   logic [6:0]  r_wr_avail;
   logic [6:0]  r_rd_pending;
   logic [2:0]  r_instr;
   logic [5:0]  r_bl;
   logic [29:0] r_addr;
   logic        r_err;

   logic [6:0]  w_wr_need;
   logic [6:0]  w_rd_need;
   logic [7:0]  w_rd_sum;
   logic        w_wr_elig;
   logic        w_rd_elig;
   logic        w_gnt_wr;
   logic        w_gnt_rd;
   logic        w_wr_push_ok;
   logic        w_wr_ovf;
   logic        w_rd_pop_ok;
   logic        w_rd_unf;
   logic [6:0]  w_wr_avail_nxt;
   logic [6:0]  w_rd_pending_nxt;

   // Eligibility from registered counters only: a push landing this cycle
   // becomes usable on the next evaluation.
   assign w_wr_need = {1'b0, wr_bl_in} + 7'd1;
   assign w_rd_need = {1'b0, rd_bl_in} + 7'd1;
   assign w_rd_sum  = {1'b0, r_rd_pending} + {2'b00, rd_bl_in} + 8'd1;

   assign w_wr_elig = (r_state == ST_IDLE) & wr_req_in & ~mcb_cmd_full_in &
                      (r_wr_avail >= w_wr_need);
   assign w_rd_elig = (r_state == ST_IDLE) & rd_req_in & ~mcb_cmd_full_in &
                      (w_rd_sum <= RD_DEPTH_W);

   // On a tie the side not granted last wins.
   assign w_gnt_wr = w_wr_elig & (~w_rd_elig | r_last_rd);
   assign w_gnt_rd = w_rd_elig & (~w_wr_elig | ~r_last_rd);

   // Monitor strobes that would push a counter out of range are dropped
   // (counter saturates) and flagged.
   assign w_wr_ovf     = mcb_wr_en_in & (r_wr_avail == WR_FULL);
   assign w_wr_push_ok = mcb_wr_en_in & ~w_wr_ovf;
   assign w_rd_unf     = mcb_rd_en_in & (r_rd_pending == 7'd0);
   assign w_rd_pop_ok  = mcb_rd_en_in & ~w_rd_unf;

   assign w_wr_avail_nxt   = r_wr_avail + 7'(w_wr_push_ok)
                             - (w_gnt_wr ? w_wr_need : 7'd0);
   assign w_rd_pending_nxt = r_rd_pending + (w_gnt_rd ? w_rd_need : 7'd0)
                             - 7'(w_rd_pop_ok);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_gnt_wr | w_gnt_rd) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      mcb_cmd_en_out        = 1'b0;
      wr_ack_out            = 1'b0;
      rd_ack_out            = 1'b0;
      mcb_cmd_instr_out     = r_instr;
      mcb_cmd_bl_out        = r_bl;
      mcb_cmd_byte_addr_out = r_addr;
      rd_pending_out        = r_rd_pending;
      err_out               = r_err;
      if (r_state == ST_ISSUE) begin
         mcb_cmd_en_out = 1'b1;
         wr_ack_out     = (r_instr == MCB_INSTR_WR);
         rd_ack_out     = (r_instr == MCB_INSTR_RD);
      end
   end

   // Command latch, last-grant tracking, credit counters, error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_rd    <= 1'b1;
         r_instr      <= 3'b000;
         r_bl         <= 6'd0;
         r_addr       <= 30'd0;
         r_wr_avail   <= 7'd0;
         r_rd_pending <= 7'd0;
         r_err        <= 1'b0;
      end else begin
         if (w_gnt_wr) begin
            r_last_rd <= 1'b0;
            r_instr   <= MCB_INSTR_WR;
            r_bl      <= wr_bl_in;
            r_addr    <= wr_addr_in & ADDR_MASK;
         end else if (w_gnt_rd) begin
            r_last_rd <= 1'b1;
            r_instr   <= MCB_INSTR_RD;
            r_bl      <= rd_bl_in;
            r_addr    <= rd_addr_in & ADDR_MASK;
         end
         r_wr_avail   <= w_wr_avail_nxt;
         r_rd_pending <= w_rd_pending_nxt;
         r_err        <= r_err | w_wr_ovf | w_rd_unf;
      end
   end

endmodule
